reg_writeback_unit: RTL and testbench

//  Write-side controller for the register file write port (i_we/i_waddr/i_wdata).

---
 rtl/reg_writeback_unit_pkg.sv | 16 +
 rtl/reg_writeback_unit_fifo.sv | 60 ++++++
 rtl/reg_writeback_unit.sv | 102 ++++++++++
 tb/tb_reg_writeback_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_unit_pkg.sv
// Shared types and constants for the register-file write-back unit.
// wb_entry_t is one pending register write: destination and data.
package reg_writeback_unit_pkg;

  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int WB_DEPTH = 4;

  localparam logic [WB_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_AW-1:0] waddr;
    logic [WB_DW-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_unit_fifo.sv
// Load-result FIFO: circular buffer of wb_entry_t with a registered occupancy count.
// A push into an empty FIFO becomes visible at o_head only on the following cycle.
module wb_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  wb_entry_t i_push_entry,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic [CW-1:0] o_count
);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;

  // NOTE: every variable gets its default before any branch, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so the pointers wrap on plain overflow.
    if (i_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (i_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({i_push, i_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count decides which slots are meaningful.
  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q] <= i_push_entry;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write-port controller: ALU results win, buffered loads fill idle cycles,
// and a per-register pending-load scoreboard tells decode which registers to stall on.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  // AW/DW must match the package entry widths.
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW,
  localparam int CW   = $clog2(DEPTH) + 1,
  localparam int NREG = 1 << AW
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_alu_valid,
  input  logic [AW-1:0]   i_alu_waddr,
  input  logic [DW-1:0]   i_alu_wdata,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [AW-1:0]   i_ld_waddr,
  input  logic [DW-1:0]   i_ld_wdata,
  input  logic            i_iss_valid,
  input  logic [AW-1:0]   i_iss_waddr,
  output logic            o_we,
  output logic [AW-1:0]   o_waddr,
  output logic [DW-1:0]   o_wdata,
  output logic [NREG-1:0] o_busy,
  output logic [CW-1:0]   o_count
);

  wb_entry_t       alu_entry, ld_entry, head, sel_entry;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty, ld_ready, push, pop, sel_valid;

  logic            we_q,    we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NREG-1:0] busy_q,  busy_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (push),
    .i_push_entry (ld_entry),
    .i_pop        (pop),
    .o_head       (head),
    .o_count      (fifo_count)
  );

  always_comb begin
    alu_entry.waddr = i_alu_waddr;
    alu_entry.wdata = i_alu_wdata;
    ld_entry.waddr  = i_ld_waddr;
    ld_entry.wdata  = i_ld_wdata;

    // Ready depends only on the registered count, never on i_ld_valid.
    fifo_empty = (fifo_count == '0);
    ld_ready   = (fifo_count != CW'(DEPTH));
    push       = i_ld_valid && ld_ready;
    pop        = !i_alu_valid && !fifo_empty;

    sel_entry  = i_alu_valid ? alu_entry : head;
    sel_valid  = i_alu_valid || pop;

    // Writes to register 0 are consumed but never reach the register file.
    we_d    = sel_valid && (sel_entry.waddr != REG_ZERO);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (we_d) begin
      waddr_d = sel_entry.waddr;
      wdata_d = sel_entry.wdata;
    end

    // Clear before set: a new issue in the retiring cycle keeps the register pending.
    busy_d = busy_q;
    if (pop)         busy_d[head.waddr]  = 1'b0;
    if (i_iss_valid) busy_d[i_iss_waddr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign o_we       = we_q;
  assign o_waddr    = waddr_q;
  assign o_wdata    = wdata_q;
  assign o_busy     = busy_q;
  assign o_count    = fifo_count;
  assign o_ld_ready = ld_ready;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: hand-derived vector table, hand-written multi-cycle sequences,
// and a queue-based reference model checked on every cycle including a random phase.
module tb_reg_writeback_unit;
  import reg_writeback_unit_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = 3;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_alu_valid, i_ld_valid, i_iss_valid;
  logic [AW-1:0] i_alu_waddr, i_ld_waddr, i_iss_waddr;
  logic [DW-1:0] i_alu_wdata, i_ld_wdata;
  logic          o_ld_ready, o_we;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic [31:0]   o_busy;
  logic [CW-1:0] o_count;

  always #5 i_clk = ~i_clk;

  reg_writeback_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_alu_valid (i_alu_valid),
    .i_alu_waddr (i_alu_waddr),
    .i_alu_wdata (i_alu_wdata),
    .i_ld_valid  (i_ld_valid),
    .o_ld_ready  (o_ld_ready),
    .i_ld_waddr  (i_ld_waddr),
    .i_ld_wdata  (i_ld_wdata),
    .i_iss_valid (i_iss_valid),
    .i_iss_waddr (i_iss_waddr),
    .o_we        (o_we),
    .o_waddr     (o_waddr),
    .o_wdata     (o_wdata),
    .o_busy      (o_busy),
    .o_count     (o_count)
  );

  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic iv; logic [4:0] ia;
  } stim_t;

  typedef struct {
    stim_t s;
    logic ew; logic [4:0] ewa; logic [31:0] ewd;
    int ecnt; logic erdy; logic [31:0] ebusy;
  } vec_t;

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic [31:0] busy; int cnt; logic rdy;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  wb_entry_t   mq[$];
  exp_t        exp_q[$];
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input int av, input int aa, input logic [31:0] ad,
                               input int lv, input int la, input logic [31:0] ld,
                               input int iv, input int ia);
    stim_t s;
    s.av = (av != 0); s.aa = 5'(aa); s.ad = ad;
    s.lv = (lv != 0); s.la = 5'(la); s.ld = ld;
    s.iv = (iv != 0); s.ia = 5'(ia);
    return s;
  endfunction

  function automatic vec_t mkv(input stim_t s, input int ew, input int ewa, input logic [31:0] ewd,
                               input int ecnt, input int erdy, input logic [31:0] ebusy);
    vec_t v;
    v.s = s; v.ew = (ew != 0); v.ewa = 5'(ewa); v.ewd = ewd;
    v.ecnt = ecnt; v.erdy = (erdy != 0); v.ebusy = ebusy;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_busy = '0; m_we = 1'b0; m_wa = '0; m_wd = '0;
  endtask

  task automatic apply_idle_inputs();
    i_alu_valid = 1'b0; i_alu_waddr = '0; i_alu_wdata = '0;
    i_ld_valid  = 1'b0; i_ld_waddr  = '0; i_ld_wdata  = '0;
    i_iss_valid = 1'b0; i_iss_waddr = '0;
  endtask

  task automatic do_reset(input int cycles);
    i_rst_n = 1'b0;
    apply_idle_inputs();
    repeat (cycles) @(posedge i_clk);
    #1;
    model_reset();
    check("rst_we",    32'(o_we),       32'd0);
    check("rst_waddr", 32'(o_waddr),    32'd0);
    check("rst_wdata", o_wdata,         32'd0);
    check("rst_busy",  o_busy,          32'd0);
    check("rst_count", 32'(o_count),    32'd0);
    check("rst_ready", 32'(o_ld_ready), 32'd1);
    i_rst_n = 1'b1;
  endtask

  // Drive one cycle, predict it with the model, then compare against the popped prediction.
  task automatic drive(input stim_t s);
    wb_entry_t e, sel;
    logic      ready, push, sel_valid;
    exp_t      x;
    i_alu_valid = s.av; i_alu_waddr = s.aa; i_alu_wdata = s.ad;
    i_ld_valid  = s.lv; i_ld_waddr  = s.la; i_ld_wdata  = s.ld;
    i_iss_valid = s.iv; i_iss_waddr = s.ia;

    ready     = (mq.size() != DEPTH);
    push      = s.lv && ready;
    sel_valid = 1'b0;
    sel       = '0;
    if (s.av) begin
      sel_valid = 1'b1; sel.waddr = s.aa; sel.wdata = s.ad;
    end else if (mq.size() > 0) begin
      sel = mq.pop_front();
      sel_valid = 1'b1;
      m_busy[sel.waddr] = 1'b0;
    end
    if (s.iv && s.ia != 5'd0) m_busy[s.ia] = 1'b1;
    if (push) begin
      e.waddr = s.la; e.wdata = s.ld;
      mq.push_back(e);
    end
    m_we = sel_valid && (sel.waddr != 5'd0);
    if (m_we) begin
      m_wa = sel.waddr; m_wd = sel.wdata;
    end
    x.we = m_we; x.wa = m_wa; x.wd = m_wd; x.busy = m_busy;
    x.cnt = mq.size(); x.rdy = (mq.size() != DEPTH);
    exp_q.push_back(x);

    @(posedge i_clk);
    #1;
    x = exp_q.pop_front();
    check("sb_we",    32'(o_we),       32'(x.we));
    check("sb_waddr", 32'(o_waddr),    32'(x.wa));
    check("sb_wdata", o_wdata,         x.wd);
    check("sb_busy",  o_busy,          x.busy);
    check("sb_count", 32'(o_count),    32'(x.cnt));
    check("sb_ready", 32'(o_ld_ready), 32'(x.rdy));
  endtask

  initial begin
    stim_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    i_rst_n = 1'b0;
    apply_idle_inputs();

    // ALU path, priority, zero register, scoreboard, load to r0, push+pop
    vecs.push_back(mkv(mk(1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0), 1, 1, 32'hDEADBEEF, 0, 1, 32'h0));
    vecs.push_back(mkv(mk(0, 0, 0, 1, 5, 32'h11111111, 1, 5), 0, 1, 32'hDEADBEEF, 1, 1, 32'h20));
    vecs.push_back(mkv(mk(1, 3, 32'hABBABAAB, 0, 0, 0, 0, 0), 1, 3, 32'hABBABAAB, 1, 1, 32'h20));
    vecs.push_back(mkv(idle,                                  1, 5, 32'h11111111, 0, 1, 32'h0));
    vecs.push_back(mkv(idle,                                  0, 5, 32'h11111111, 0, 1, 32'h0));
    vecs.push_back(mkv(mk(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0), 0, 5, 32'h11111111, 0, 1, 32'h0));
    vecs.push_back(mkv(mk(0, 0, 0, 0, 0, 0, 1, 0),            0, 5, 32'h11111111, 0, 1, 32'h0));
    vecs.push_back(mkv(mk(0, 0, 0, 0, 0, 0, 1, 7),            0, 5, 32'h11111111, 0, 1, 32'h80));
    vecs.push_back(mkv(mk(1, 2, 32'h22222222, 1, 7, 32'h777, 0, 0), 1, 2, 32'h22222222, 1, 1, 32'h80));
    vecs.push_back(mkv(idle,                                  1, 7, 32'h777, 0, 1, 32'h0));
    vecs.push_back(mkv(mk(0, 0, 0, 0, 0, 0, 1, 7),            0, 7, 32'h777, 0, 1, 32'h80));
    vecs.push_back(mkv(mk(1, 4, 32'h44, 1, 7, 32'h77, 0, 0),  1, 4, 32'h44, 1, 1, 32'h80));
    vecs.push_back(mkv(mk(0, 0, 0, 0, 0, 0, 1, 7),            1, 7, 32'h77, 0, 1, 32'h80));
    vecs.push_back(mkv(mk(1, 1, 32'h1, 1, 7, 32'h78, 0, 0),   1, 1, 32'h1, 1, 1, 32'h80));
    vecs.push_back(mkv(idle,                                  1, 7, 32'h78, 0, 1, 32'h0));
    vecs.push_back(mkv(mk(0, 0, 0, 1, 0, 32'hCAFE, 0, 0),     0, 7, 32'h78, 1, 1, 32'h0));
    vecs.push_back(mkv(idle,                                  0, 7, 32'h78, 0, 1, 32'h0));
    vecs.push_back(mkv(mk(0, 0, 0, 1, 9, 32'h99, 0, 0),       0, 7, 32'h78, 1, 1, 32'h0));
    vecs.push_back(mkv(mk(0, 0, 0, 1, 10, 32'hAA, 0, 0),      1, 9, 32'h99, 1, 1, 32'h0));
    vecs.push_back(mkv(idle,                                  1, 10, 32'hAA, 0, 1, 32'h0));
    vecs.push_back(mkv(idle,                                  0, 10, 32'hAA, 0, 1, 32'h0));

    do_reset(2);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s);
      check($sformatf("v%0d_we", i),    32'(o_we),       32'(vecs[i].ew));
      check($sformatf("v%0d_waddr", i), 32'(o_waddr),    32'(vecs[i].ewa));
      check($sformatf("v%0d_wdata", i), o_wdata,         vecs[i].ewd);
      check($sformatf("v%0d_count", i), 32'(o_count),    32'(vecs[i].ecnt));
      check($sformatf("v%0d_ready", i), 32'(o_ld_ready), 32'(vecs[i].erdy));
      check($sformatf("v%0d_busy", i),  o_busy,          vecs[i].ebusy);
    end

    // Fill the FIFO while the ALU starves it, offer one more load, then drain in order.
    for (int k = 0; k < 4; k++) begin
      drive(mk(1, 11 + k, 32'hA0 + 32'(k), 1, 20 + k, 32'h1000 + 32'(k), 0, 0));
      check($sformatf("fill%0d_waddr", k), 32'(o_waddr),    32'(11 + k));
      check($sformatf("fill%0d_count", k), 32'(o_count),    32'(k + 1));
      check($sformatf("fill%0d_ready", k), 32'(o_ld_ready), (k < 3) ? 32'd1 : 32'd0);
    end
    drive(mk(1, 15, 32'hA4, 1, 25, 32'hBAD, 0, 0));
    check("full_count", 32'(o_count),    32'd4);
    check("full_ready", 32'(o_ld_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(idle);
      check($sformatf("drain%0d_we", k),    32'(o_we),       32'd1);
      check($sformatf("drain%0d_waddr", k), 32'(o_waddr),    32'(20 + k));
      check($sformatf("drain%0d_wdata", k), o_wdata,         32'h1000 + 32'(k));
      check($sformatf("drain%0d_count", k), 32'(o_count),    32'(3 - k));
      check($sformatf("drain%0d_ready", k), 32'(o_ld_ready), 32'd1);
    end
    drive(idle);
    check("drained_we", 32'(o_we), 32'd0);

    // Reset with buffered loads and pending registers discards everything.
    drive(mk(1, 1, 32'h1, 1, 6, 32'h66, 1, 6));
    drive(mk(1, 2, 32'h2, 1, 8, 32'h88, 1, 8));
    check("pre_rst_count", 32'(o_count), 32'd2);
    check("pre_rst_busy",  o_busy,       32'h140);
    do_reset(1);
    drive(idle);
    check("post_rst_we", 32'(o_we), 32'd0);

    // Random traffic against the reference model, alternating heavy and light ALU load.
    for (int i = 0; i < 400; i++) begin
      int alu_pct;
      stim_t s;
      alu_pct = ((i / 40) % 2 == 0) ? 75 : 20;
      s.av = ($urandom_range(0, 99) < alu_pct);
      s.aa = 5'($urandom_range(0, 31));
      s.ad = $urandom();
      s.lv = ($urandom_range(0, 99) < 50);
      s.la = 5'($urandom_range(0, 31));
      s.ld = $urandom();
      s.iv = ($urandom_range(0, 99) < 40);
      s.ia = 5'($urandom_range(0, 31));
      drive(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
